id_issue_queue: RTL and testbench

ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

---
 rtl/id_issue_queue.sv | 101 ++++++++++
 tb/tb_id_issue_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - in-order decode-to-issue queue; optional stall counter under ID_ISSUE_QUEUE_STALL_CNT_EN
package id_issue_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } scoreboard_entry_t;
endpackage

module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  scoreboard_entry_t        in_instr_i,
  input  logic                     in_is_ctrl_flow_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output scoreboard_entry_t        out_instr_o,
  output logic                     out_is_ctrl_flow_o,
  output logic                     out_valid_o,
  input  logic                     out_ack_i,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef ID_ISSUE_QUEUE_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Payload storage carries no reset; only the occupancy bookkeeping does.
  scoreboard_entry_t instr_mem [DEPTH];
  logic [DEPTH-1:0]  ctrl_mem;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Handshake flags depend only on registered occupancy, so ready never
  // looks at the consumer's ack and the head is never bypassed from input.
  assign in_ready_o         = (count < CW'(DEPTH));
  assign out_valid_o        = (count != '0);
  assign out_instr_o        = instr_mem[rd_ptr];
  assign out_is_ctrl_flow_o = ctrl_mem[rd_ptr];
  assign count_o            = count;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ack_i && !flush_i;

  // Write the offered entry into the tail slot on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr_i;
      ctrl_mem[wr_ptr]  <= in_is_ctrl_flow_i;
    end
  end

  // Pointer and occupancy tracking; flush outranks push and pop.
  // Pointers are exactly PW bits wide so DEPTH-1 + 1 wraps to 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ID_ISSUE_QUEUE_STALL_CNT_EN
  // Count cycles the decoder was held off by a full queue; survives flush,
  // saturates rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (in_valid_i && !in_ready_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// tb/tb_id_issue_queue.sv - directed self-checking bench for id_issue_queue
module tb_id_issue_queue;
  import id_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  scoreboard_entry_t in_instr_i;
  logic              in_is_ctrl_flow_i;
  logic              in_valid_i;
  logic              in_ready_o;
  scoreboard_entry_t out_instr_o;
  logic              out_is_ctrl_flow_o;
  logic              out_valid_o;
  logic              out_ack_i;
  logic [2:0]        count_o;
`ifdef ID_ISSUE_QUEUE_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  id_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .in_instr_i         (in_instr_i),
    .in_is_ctrl_flow_i  (in_is_ctrl_flow_i),
    .in_valid_i         (in_valid_i),
    .in_ready_o         (in_ready_o),
    .out_instr_o        (out_instr_o),
    .out_is_ctrl_flow_o (out_is_ctrl_flow_o),
    .out_valid_o        (out_valid_o),
    .out_ack_i          (out_ack_i),
    .count_o            (count_o)
`ifdef ID_ISSUE_QUEUE_STALL_CNT_EN
    ,
    .stall_cnt_o        (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Count one comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input int n);
    scoreboard_entry_t e;
    e.pc  = 32'h8000_0000 + 32'(n * 4);
    e.op  = 8'(n + 8'h40);
    e.rd  = 5'(n);
    e.rs1 = 5'(n + 1);
    e.rs2 = 5'(n + 2);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input int n, input logic tag, input logic ack);
    in_valid_i        = v;
    in_instr_i        = mk(n);
    in_is_ctrl_flow_i = tag;
    out_ack_i         = ack;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    #2;
    check("reset_count", 64'(count_o), 64'd0);
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_in_ready", 64'(in_ready_o), 64'd1);
`ifdef ID_ISSUE_QUEUE_STALL_CNT_EN
    check("reset_stall", 64'(stall_cnt_o), 64'd0);
`endif
    tick();
    tick();
    rst_i = 1'b0;

    // Fill A..D (ids 1..4) with no ack; head must not bypass from input.
    drive(1'b1, 1, 1'b1, 1'b0);
    #1;
    check("no_bypass", 64'(out_valid_o), 64'd0);
    tick();
    check("fill1_count", 64'(count_o), 64'd1);
    check("fill1_head", 64'(out_instr_o), 64'(mk(1)));
    drive(1'b1, 2, 1'b0, 1'b0); tick();
    drive(1'b1, 3, 1'b1, 1'b0); tick();
    drive(1'b1, 4, 1'b0, 1'b0); tick();
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready", 64'(in_ready_o), 64'd0);
    check("hold_head", 64'(out_instr_o), 64'(mk(1)));
    check("hold_tag", 64'(out_is_ctrl_flow_o), 64'd1);
    // Full: offer id 9 while acking; no push may happen.
    drive(1'b1, 9, 1'b1, 1'b1);
    #1;
    check("full_ack_ready", 64'(in_ready_o), 64'd0);
    tick();
    check("full_ack_count", 64'(count_o), 64'd3);
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      check($sformatf("drain_head%0d", i), 64'(out_instr_o), 64'(mk(i)));
      check($sformatf("drain_tag%0d", i), 64'(out_is_ctrl_flow_o), 64'(i[0]));
      tick();
    end
    check("drained_count", 64'(count_o), 64'd0);
    check("drained_valid", 64'(out_valid_o), 64'd0);

    // Ack on empty queue must change nothing.
    drive(1'b0, 0, 1'b0, 1'b1); tick();
    check("empty_ack_count", 64'(count_o), 64'd0);
    drive(1'b1, 20, 1'b0, 1'b0); tick();
    check("after_empty_ack_head", 64'(out_instr_o), 64'(mk(20)));

    // Simultaneous push/pop at count 2.
    drive(1'b1, 21, 1'b1, 1'b0); tick();
    check("two_count", 64'(count_o), 64'd2);
    drive(1'b1, 22, 1'b0, 1'b1); tick();
    check("pp_count", 64'(count_o), 64'd2);
    check("pp_head", 64'(out_instr_o), 64'(mk(21)));
    drive(1'b0, 0, 1'b0, 1'b1); tick();
    check("pp_tail", 64'(out_instr_o), 64'(mk(22)));
    drive(1'b0, 0, 1'b0, 1'b1); tick();
    check("pp_empty", 64'(count_o), 64'd0);

    // Ten push/pop pairs across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 30 + i, logic'((i % 3) == 0), logic'(i > 0));
      if (i > 0) begin
        check($sformatf("wrap_head%0d", i - 1), 64'(out_instr_o), 64'(mk(30 + i - 1)));
        check($sformatf("wrap_tag%0d", i - 1), 64'(out_is_ctrl_flow_o), 64'(((i - 1) % 3) == 0));
      end
      tick();
    end
    check("wrap_count", 64'(count_o), 64'd1);
    check("wrap_last", 64'(out_instr_o), 64'(mk(39)));
    drive(1'b0, 0, 1'b0, 1'b1); tick();

    // Flush with push and ack in the same cycle.
    drive(1'b1, 50, 1'b0, 1'b0); tick();
    drive(1'b1, 51, 1'b0, 1'b0); tick();
    drive(1'b1, 52, 1'b0, 1'b0); tick();
    check("preflush_count", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    drive(1'b1, 53, 1'b1, 1'b1); tick();
    flush_i = 1'b0;
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(out_valid_o), 64'd0);
    drive(1'b1, 54, 1'b0, 1'b0); tick();
    check("postflush_head", 64'(out_instr_o), 64'(mk(54)));
    check("postflush_count", 64'(count_o), 64'd1);

    // Async reset between edges with two entries queued.
    drive(1'b1, 55, 1'b0, 1'b0); tick();
    drive(1'b0, 0, 1'b0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_ready", 64'(in_ready_o), 64'd1);
    check("arst_count", 64'(count_o), 64'd0);
    #1;
    rst_i = 1'b0;
    drive(1'b1, 60, 1'b1, 1'b0); tick();
    check("arst_first_push", 64'(count_o), 64'd1);
    check("arst_first_head", 64'(out_instr_o), 64'(mk(60)));

`ifdef ID_ISSUE_QUEUE_STALL_CNT_EN
    drive(1'b1, 61, 1'b0, 1'b0); tick();
    drive(1'b1, 62, 1'b0, 1'b0); tick();
    drive(1'b1, 63, 1'b0, 1'b0); tick();
    check("stall_pre", 64'(stall_cnt_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64, 1'b0, 1'b0); tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    check("stall_five", 64'(stall_cnt_o), 64'd5);
    flush_i = 1'b1; tick();
    flush_i = 1'b0;
    check("stall_after_flush", 64'(stall_cnt_o), 64'd5);
`endif

    drive(1'b0, 0, 1'b0, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
